// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline types for the hazard unit slice.
//   regbits_t      - 5-bit architectural register index
//   hazard_state_t - hazard unit FSM state (RUN, DWAIT, HALTED)
//   load_use_hit() - detects a load in ID/EX feeding an instruction in IF/ID
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    // Register 0 is hardwired to zero, so a load targeting it never creates
    // a real dependency and must not stall.
    function automatic logic load_use_hit(
        input logic     ex_dren,
        input regbits_t ex_wsel,
        input regbits_t id_rs,
        input regbits_t id_rt
    );
        return ex_dren && (ex_wsel != '0) &&
               ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: bundle between the pipeline datapath and the hazard unit.
//   Pipeline -> hazard unit : ihit, dhit, mem_dREN, mem_dWEN, ex_dREN,
//                             ex_wsel, id_rs, id_rt, branch_taken, jump_id,
//                             halt_wb
//   Hazard unit -> pipeline : pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                             ifid_flush, idex_flush, exmem_flush,
//                             memwb_flush, halted
// master = pipeline side, slave = hazard unit side.
interface hazard_unit_if;
    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     mem_dREN;
    logic     mem_dWEN;
    logic     ex_dREN;
    regbits_t ex_wsel;
    regbits_t id_rs;
    regbits_t id_rt;
    logic     branch_taken;
    logic     jump_id;
    logic     halt_wb;

    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     memwb_flush;
    logic     halted;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               branch_taken, jump_id, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               branch_taken, jump_id, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: saturating up-counter used for the hazard performance counters.
//   CLK   - clock, rising edge
//   RST   - synchronous active-high clear
//   inc   - count enable for this cycle
//   count - current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush controller for a 5-stage CPU.
//   CLK, RST            - clock and synchronous active-high reset
//   hif (slave)         - hazard inputs from the datapath, stage enables,
//                         bubble requests and sticky halted flag back
//   stall_cnt           - saturating count of cycles with pc_en low (not halted)
//   flush_cnt           - saturating count of cycles with any flush request
// Resolution order: halted, data-memory wait, taken branch, load-use,
// jump in ID, instruction-fetch miss.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    hazard_unit_if.slave     hif,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_t state_q;
    logic          halted_q;

    logic mem_wait;
    logic ld_use;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic stall_inc, flush_inc;

    always_comb begin
        // Once in DWAIT the memory op is still outstanding regardless of how
        // the request strobes look; only dhit releases the wait.
        if (state_q == DWAIT) begin
            mem_wait = ~hif.dhit;
        end else begin
            mem_wait = (hif.mem_dREN | hif.mem_dWEN) & ~hif.dhit;
        end

        ld_use = load_use_hit(hif.ex_dREN, hif.ex_wsel, hif.id_rs, hif.id_rt);

        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        // Reset forces the free-running defaults above.
        if (!RST) begin
            if (state_q == HALTED) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (mem_wait) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end else if (hif.branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (ld_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (hif.jump_id) begin
                ifid_flush = 1'b1;
            end else if (!hif.ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end

        stall_inc = ~pc_en & (state_q != HALTED);
        flush_inc = ifid_flush | idex_flush | exmem_flush | memwb_flush;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_q | hif.halt_wb;
            if (hif.halt_wb) begin
                state_q <= HALTED;
            end else begin
                case (state_q)
                    RUN, DWAIT: state_q <= mem_wait ? DWAIT : RUN;
                    HALTED:     state_q <= HALTED;
                    default:    state_q <= RUN;
                endcase
            end
        end
    end

    assign hif.pc_en       = pc_en;
    assign hif.ifid_en     = ifid_en;
    assign hif.idex_en     = idex_en;
    assign hif.exmem_en    = exmem_en;
    assign hif.memwb_en    = memwb_en;
    assign hif.ifid_flush  = ifid_flush;
    assign hif.idex_flush  = idex_flush;
    assign hif.exmem_flush = exmem_flush;
    assign hif.memwb_flush = memwb_flush;
    assign hif.halted      = halted_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
